// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and one-hot grant constants for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational 2-way round-robin picker returning a one-hot winner
module rr_pick2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic [1:0] last,
  output logic [1:0] win
);
  // on a tie the master that did not win last time goes first; otherwise the lone requester wins
  always_comb win = (req == 2'b11) ? ((last == GNT_IFU) ? GNT_LSU : GNT_IFU) : req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU with one outstanding transaction
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_rdata,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            grant
);
  state_t state, state_nxt;
  logic [1:0] last, pick, accept;
  logic resp_hit;
  rr_pick2 u_pick (.req({lsu_req_valid, ifu_req_valid}), .last(last), .win(pick));
  // readies are held low while reset is asserted so a waiting master never sees a spurious accept
  assign accept = (state == IDLE && !rst) ? pick : GNT_NONE;
  assign ifu_req_ready = accept[0];
  assign lsu_req_ready = accept[1];
  assign resp_hit = (state == RESP) && mem_resp_valid;
  assign mem_req_valid = (state == REQ);
  assign ifu_resp_valid = resp_hit & grant[0];
  assign lsu_resp_valid = resp_hit & grant[1];
  assign ifu_rdata = ifu_resp_valid ? mem_rdata : '0;
  assign lsu_rdata = lsu_resp_valid ? mem_rdata : '0;
  // next state: accept -> present to memory -> await response -> idle
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && |accept) ? REQ :
                (state == REQ && mem_req_ready) ? RESP :
                resp_hit ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // grant, last winner and the latched request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= GNT_NONE;
      last      <= GNT_LSU;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else if (|accept) begin
      grant     <= accept;
      last      <= accept;
      mem_addr  <= accept[1] ? lsu_addr : ifu_addr;
      mem_wen   <= accept[1] & lsu_wen;
      mem_wdata <= accept[1] ? lsu_wdata : '0;
      mem_wmask <= accept[1] ? lsu_wmask : '0;
    end else if (resp_hit) begin
      grant <= GNT_NONE;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). The arbiter runs a three-state request/response sequencer. It latches the winning request and forwards it to memory. It returns the response only to the granted master. It also drives a one-hot grant that steers the downstream data-return muxes. It sits between IFU/LSU and the memory/bus bridge and allows one outstanding transaction at a time.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be a multiple of 8
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU read address
- ifu_resp_valid  out  1  IFU response pulse
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  ADDR_W  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_W  write data
- lsu_wmask  in  DATA_W/8  byte write enables
- lsu_resp_valid  out  1  LSU response pulse; for writes this is the acknowledge
- lsu_rdata  out  DATA_W  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr / mem_wen / mem_wdata / mem_wmask  out  ADDR_W / 1 / DATA_W / DATA_W/8  forwarded request fields
- mem_resp_valid  in  1  memory response pulse
- mem_rdata  in  DATA_W  memory read data
- grant  out  2  one-hot owner: bit0 = IFU, bit1 = LSU; 2'b00 when idle

## Operation
- States:
  - IDLE: no transaction in flight.
  - REQ: the latched request is presented to memory.
  - RESP: waiting for the memory response.
- IDLE, any req_valid high:
  - Select a winner.
  - Pulse the winner's req_ready for one cycle.
  - Latch addr, wen, wdata and wmask. IFU is forced to wen=0 and wmask=0.
  - Set grant to the winner; go to REQ.
- IDLE, no req_valid: req_ready outputs are 0 and the state holds.
- REQ:
  - mem_req_valid=1 and the mem_* fields come from the latched registers, stable until the handshake.
  - On mem_req_ready, go to RESP.
- RESP:
  - On mem_resp_valid, pulse resp_valid to the granted master only.
  - Pass mem_rdata through combinationally to the granted master's rdata.
  - Go to IDLE and clear grant.
- rdata of the non-granted master is 0. rdata of either master is 0 when no response is being returned.
- Arbitration is 2-way round-robin:
  - A single-requester cycle always grants that requester.
  - When both request, the master that did not win the last grant wins.
  - The last-winner register resets to LSU, so IFU wins the first tie.
- No request is accepted outside IDLE. A master holding req_valid simply waits; the arbiter imposes no requirement on req_valid stability.
- A mem_resp_valid outside RESP is ignored. It produces no resp_valid pulse and no state change.

## Timing
- Reset (asynchronous): state=IDLE, grant=0, last-winner=LSU, all *_ready/*_valid outputs 0, all latched fields 0. Every data output is 0.
- Reset mid-transaction drops the transaction. Memory must be reset in the same domain.
- Request acceptance: req_ready in cycle N, mem_req_valid from cycle N+1.
- Minimum transaction is 3 cycles from acceptance to the next possible acceptance (accept, REQ with ready, RESP with valid). The next grant can be given in the cycle after resp_valid.
- mem_req_ready and mem_resp_valid are each sampled only in their own state. A same-cycle mem_resp_valid in REQ is ignored.
- req_ready is combinational from req_valid and the state; resp outputs are combinational from mem_resp_valid and grant. No other combinational paths exist from inputs to outputs.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, REQ, RESP)
  - the grant constants GNT_NONE=2'b00, GNT_IFU=2'b01, GNT_LSU=2'b10
- Sub-module rr_pick2 is a combinational 2-way round-robin picker:
  - inputs: req[1:0] and last[1:0]
  - output: a one-hot winner
- grant feeds the existing one-hot select muxes in the return path directly.

## Test plan
- Lone IFU read of addr 0x8000_0000, memory ready same cycle, rdata 0x0000_0413 two cycles later:
  - ifu_resp_valid is a 1-cycle pulse with ifu_rdata=0x0000_0413.
  - lsu_resp_valid stays 0.
  - grant goes 01 then 00.
- Simultaneous IFU/LSU requests held high for 4 transactions:
  - Grant order IFU, LSU, IFU, LSU.
  - Each master sees exactly 2 req_ready pulses.
- LSU write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b0011, memory stalls ready 5 cycles:
  - mem_* fields stay stable through the stall; mem_wen=1.
  - A single lsu_resp_valid is seen.
- Stray mem_resp_valid in IDLE and in REQ: no resp pulse, state unchanged.
- Reset asserted in RESP, asynchronously mid-cycle:
  - All outputs go to 0 immediately.
  - After release, an IFU request is granted first.
